ahb_cfg_master: RTL and testbench

Single-outstanding AHB-lite initiator that turns a simple command/response interface into word-sized AHB register transfers. Its job is to program and read back AHB configuration slaves such as the IOPMP config port (per-port enable, region base/mask registers) from a boot sequencer or debug path. It drives the slave-side signals (`hsel`, `haddr`, `htrans`, `hwdata`, ...) and consumes `hready`, `hresp` and `hrdata`.

---
 rtl/ahb_cfg_master.sv | 219 +++++++++++++++++++++
 tb/tb_ahb_cfg_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cfg_master.sv
// ahb_cfg_master
// Single-outstanding AHB-lite initiator. It turns a simple command/response
// handshake into one word-sized SINGLE transfer per command. It is used to
// program and read back AHB configuration slaves.
//
// Optional feature macro: AHB_CFG_MASTER_VERIFY_EN
//   When this macro is defined, every write that completes OKAY is followed
//   by a readback of the same address. The readback is compared against the
//   written data under cmd_vmask.
//
// Ports
//   hclk, hreset        clock and synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_ready is high only in IDLE
//   cmd_write           1 = write, 0 = read
//   cmd_addr            byte address; bits [1:0] are ignored
//   cmd_wdata           write data
//   cmd_vmask           readback compare mask (verify build only)
//   rsp_valid           one-cycle response pulse, with no backpressure
//   rsp_rdata           read data, or readback data when verifying
//   rsp_err             the slave returned a non-OKAY response
//   rsp_mismatch        the verify compare failed
//   hsel .. hwdata      AHB-lite initiator outputs
//   hresp, hready, hrdata  AHB-lite slave responses
module ahb_cfg_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH-1:0] cmd_vmask,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_mismatch,
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [3:0]            hprot,
  output logic [2:0]            hsize,
  output logic [1:0]            htrans,
  output logic [2:0]            hburst,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [1:0]            hresp,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

`ifdef AHB_CFG_MASTER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_RESP, S_VADDR, S_VDATA
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_RESP
  } state_t;
`endif

  state_t                state;
  logic                  write_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;

  // Every transfer is a privileged data word SINGLE.
  assign hsize  = 3'b010;
  assign hburst = 3'b000;
  assign hprot  = 4'b0011;

  // The low address bits are always forced to zero, so they never reach the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

`ifdef AHB_CFG_MASTER_VERIFY_EN
  logic [DATA_WIDTH-1:0] vmask_p0;
  logic                  mismatch_p0;
  assign rsp_mismatch = mismatch_p0;

  function automatic logic verify_fail(input logic [DATA_WIDTH-1:0] rb,
                                       input logic [DATA_WIDTH-1:0] wd,
                                       input logic [DATA_WIDTH-1:0] mask);
    return |((rb ^ wd) & mask);
  endfunction
`else
  logic unused_vmask;
  assign unused_vmask = ^cmd_vmask;
  assign rsp_mismatch = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      hsel      <= 1'b0;
      haddr     <= '0;
      htrans    <= HTRANS_IDLE;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      write_p0  <= 1'b0;
      wdata_p0  <= '0;
`ifdef AHB_CFG_MASTER_VERIFY_EN
      vmask_p0    <= '0;
      mismatch_p0 <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            write_p0  <= cmd_write;
            wdata_p0  <= cmd_wdata;
`ifdef AHB_CFG_MASTER_VERIFY_EN
            vmask_p0  <= cmd_vmask;
`endif
            haddr     <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            hwrite    <= cmd_write;
            hsel      <= 1'b1;
            htrans    <= HTRANS_NONSEQ;
            state     <= S_ADDR;
          end
        end

        // The address phase completes on the first edge where hready is high.
        S_ADDR: begin
          if (hready) begin
            hsel   <= 1'b0;
            htrans <= HTRANS_IDLE;
            hwdata <= wdata_p0;
            state  <= S_DATA;
          end
        end

        // hwdata is only loaded on the address-to-data transition. It therefore
        // stays stable through the rest of the command, including any readback.
        // This lets a slave that commits the write one cycle late still see it.
        S_DATA: begin
          if (hready) begin
            if (hresp != HRESP_OKAY) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
`ifdef AHB_CFG_MASTER_VERIFY_EN
              mismatch_p0 <= 1'b0;
`endif
              state     <= S_RESP;
            end
`ifdef AHB_CFG_MASTER_VERIFY_EN
            else if (write_p0) begin
              hsel   <= 1'b1;
              htrans <= HTRANS_NONSEQ;
              hwrite <= 1'b0;
              state  <= S_VADDR;
            end
`endif
            else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= write_p0 ? '0 : hrdata;
              rsp_err   <= 1'b0;
`ifdef AHB_CFG_MASTER_VERIFY_EN
              mismatch_p0 <= 1'b0;
`endif
              state     <= S_RESP;
            end
          end
        end

`ifdef AHB_CFG_MASTER_VERIFY_EN
        S_VADDR: begin
          if (hready) begin
            hsel   <= 1'b0;
            htrans <= HTRANS_IDLE;
            state  <= S_VDATA;
          end
        end

        S_VDATA: begin
          if (hready) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
            if (hresp != HRESP_OKAY) begin
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              mismatch_p0 <= 1'b0;
            end else begin
              rsp_rdata   <= hrdata;
              rsp_err     <= 1'b0;
              mismatch_p0 <= verify_fail(hrdata, wdata_p0, vmask_p0);
            end
          end
        end
`endif

        S_RESP: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          cmd_ready <= 1'b0;
          hsel      <= 1'b0;
          htrans    <= HTRANS_IDLE;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_cfg_master.sv
// Testbench for ahb_cfg_master. It pairs a table of single transfers with
// hand-written wait-state, error and reset sequences. A small behavioural AHB
// slave provides the bus responses.
module tb_ahb_cfg_master;
`ifdef AHB_CFG_MASTER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, cmd_vmask = '0;
  logic        rsp_valid, rsp_err, rsp_mismatch;
  logic [31:0] rsp_rdata;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [3:0]  hprot;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [1:0]  hresp = 2'b00;
  logic        hready = 1'b1;
  logic [31:0] hrdata = '0;

  always #5 hclk = ~hclk;

  ahb_cfg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_vmask(cmd_vmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_mismatch(rsp_mismatch),
    .hsel(hsel), .haddr(haddr), .hprot(hprot), .hsize(hsize), .htrans(htrans),
    .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata),
    .hresp(hresp), .hready(hready), .hrdata(hrdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural slave configuration.
  int          aw = 0, dw = 0;
  logic [1:0]  err_code = 2'b00;
  logic [31:0] rd_val = '0;
  // Behavioural slave state and observation log.
  int          acnt = 0, dcnt = 0, nonseq_cycles = 0, accepts = 0, busy_ready = 0;
  bit          in_data = 0, data_write = 0, addr_unstable = 0, hw_unstable = 0;
  logic [31:0] a0, hw0, log_hwdata;
  logic [31:0] log_addr[$];
  bit          log_write[$];

  always @(posedge hclk) begin
    if (hreset) begin
      in_data = 0; acnt = 0; dcnt = 0;
    end else begin
      if (cmd_valid && cmd_ready) accepts++;
      if (in_data) begin
        if (dcnt == 0) hw0 = hwdata;
        else if (hwdata !== hw0) hw_unstable = 1;
        if (hready) begin
          in_data = 0; dcnt = 0;
          if (data_write) log_hwdata = hwdata;
        end else dcnt++;
      end else if (htrans == 2'b10 && hsel) begin
        nonseq_cycles++;
        if (acnt == 0) a0 = haddr;
        else if (haddr !== a0) addr_unstable = 1;
        if (hready) begin
          in_data = 1; acnt = 0; data_write = hwrite;
          log_addr.push_back(haddr); log_write.push_back(hwrite);
        end else acnt++;
      end
    end
  end

  always @(negedge hclk) begin
    hresp  = 2'b00;
    hready = 1'b1;
    hrdata = 32'hDEAD_BEEF;
    if (in_data) begin
      hrdata = rd_val;
      if (dcnt < dw) hready = 1'b0;
      if (err_code != 2'b00 && dcnt + 1 >= dw) hresp = err_code;
    end else if (htrans == 2'b10 && hsel) begin
      hready = (acnt >= aw);
    end
  end

  // Scoreboard: expectations are pushed at issue and popped on each response.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mism;
  } exp_t;
  exp_t sb[$];

  always @(negedge hclk) begin
    exp_t e;
    if (!hreset && rsp_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, expected none");
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_mismatch", {31'b0, rsp_mismatch}, {31'b0, e.mism});
      end
    end
  end

  // Issues one command. It must be called just after a falling edge, and it
  // returns on the falling edge where rsp_valid is seen. lat counts falling
  // edges after the accepting rising edge.
  task automatic run_cmd(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] vm, input bit hold, output int lat);
    int guard;
    cmd_write = w; cmd_addr = addr; cmd_wdata = wd; cmd_vmask = vm; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge hclk); guard++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got cmd_ready=0, expected 1");
    end
    busy_ready = 0;
    @(negedge hclk);
    lat = 1;
    if (!hold) cmd_valid = 1'b0;
    while (!rsp_valid && lat < 60) begin
      if (cmd_ready) busy_ready++;
      @(negedge hclk);
      lat++;
    end
    cmd_valid = 1'b0;
    if (!rsp_valid) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got no rsp_valid, expected one");
    end
  endtask

  task automatic clear_log();
    log_addr.delete(); log_write.delete();
    nonseq_cycles = 0; addr_unstable = 0; hw_unstable = 0; log_hwdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsel"}, {31'b0, hsel}, 32'd0);
    check({tag, "_haddr"}, haddr, 32'd0);
    check({tag, "_htrans"}, {30'b0, htrans}, 32'd0);
    check({tag, "_hwrite"}, {31'b0, hwrite}, 32'd0);
    check({tag, "_hwdata"}, hwdata, 32'd0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    check({tag, "_rsp_mismatch"}, {31'b0, rsp_mismatch}, 32'd0);
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] vmask;
    logic [31:0] rd;
    logic [31:0] exp_haddr;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vt[6];
    int lat, exp_lat, acc0;
    exp_t e;

    vt[0] = '{1'b1, 32'h0000_0010, 32'h2000_0000, 32'hFFFF_FFFF, 32'h2000_0000, 32'h0000_0010, 32'h0};
    vt[1] = '{1'b0, 32'h0000_0014, 32'h0,         32'h0,         32'hFFFF_F000, 32'h0000_0014, 32'hFFFF_F000};
    vt[2] = '{1'b0, 32'h0000_0017, 32'h0,         32'h0,         32'h1234_5678, 32'h0000_0014, 32'h1234_5678};
    vt[3] = '{1'b1, 32'h0000_0003, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h0000_0000, 32'h0};
    vt[4] = '{1'b0, 32'hFFFF_FFFE, 32'h0,         32'h0,         32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0001};
    vt[5] = '{1'b1, 32'h8000_0104, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FF00, 32'h8000_0104, 32'h0};

    // Reset state.
    repeat (3) @(negedge hclk);
    check_reset_outputs("reset");
    check("reset_hsize", {29'b0, hsize}, 32'd2);
    check("reset_hburst", {29'b0, hburst}, 32'd0);
    check("reset_hprot", {28'b0, hprot}, 32'd3);
    hreset = 1'b0;
    @(negedge hclk);
    check("ready_after_reset", {31'b0, cmd_ready}, 32'd1);

    // Table of zero-wait single transfers.
    for (int i = 0; i < 6; i++) begin
      aw = 0; dw = 0; err_code = 2'b00; rd_val = vt[i].rd;
      clear_log();
      e.rdata = (vt[i].w && !VERIFY) ? 32'h0 : vt[i].exp_rdata;
      if (VERIFY && vt[i].w) e.rdata = vt[i].rd;
      e.err   = 1'b0;
      e.mism  = VERIFY && vt[i].w && (|((vt[i].rd ^ vt[i].wdata) & vt[i].vmask));
      sb.push_back(e);
      run_cmd(vt[i].w, vt[i].addr, vt[i].wdata, vt[i].vmask, 1'b0, lat);
      exp_lat = (VERIFY && vt[i].w) ? 5 : 3;
      check($sformatf("v%0d_latency", i), lat, exp_lat);
      check($sformatf("v%0d_haddr", i), (log_addr.size() > 0) ? log_addr[0] : 32'hX, vt[i].exp_haddr);
      check($sformatf("v%0d_hwrite", i), (log_write.size() > 0) ? {31'b0, log_write[0]} : 32'hX, {31'b0, vt[i].w});
      check($sformatf("v%0d_nonseq", i), nonseq_cycles, (VERIFY && vt[i].w) ? 2 : 1);
      check($sformatf("v%0d_busy_ready", i), busy_ready, 0);
      if (vt[i].w) check($sformatf("v%0d_hwdata", i), log_hwdata, vt[i].wdata);
      @(negedge hclk);
      check($sformatf("v%0d_ready_after", i), {31'b0, cmd_ready}, 32'd1);
    end

    // Wait states: 2 in the address phase, 3 in the data phase, cmd_valid held high.
    aw = 2; dw = 3; err_code = 2'b00; rd_val = 32'h1234_5678;
    clear_log();
    acc0 = accepts;
    sb.push_back('{VERIFY ? 32'h1234_5678 : 32'h0, 1'b0, 1'b0});
    run_cmd(1'b1, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, lat);
    check("ws_latency", lat, VERIFY ? 15 : 8);
    check("ws_nonseq", nonseq_cycles, VERIFY ? 6 : 3);
    check("ws_addr_held", {31'b0, addr_unstable}, 32'd0);
    check("ws_hwdata_held", {31'b0, hw_unstable}, 32'd0);
    check("ws_hwdata", log_hwdata, 32'h1234_5678);
    check("ws_accepts", accepts - acc0, 1);
    check("ws_busy_ready", busy_ready, 0);
    @(negedge hclk);

    // Two-cycle ERROR response on a read.
    aw = 0; dw = 1; err_code = 2'b01; rd_val = 32'hFFFF_FFFF;
    clear_log();
    sb.push_back('{32'h0, 1'b1, 1'b0});
    run_cmd(1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b0, lat);
    check("err_latency", lat, 4);
    @(negedge hclk);
    check("err_ready_after", {31'b0, cmd_ready}, 32'd1);

    // RETRY encoding on a write counts as an error and suppresses verify.
    aw = 0; dw = 1; err_code = 2'b10; rd_val = 32'h5555_5555;
    clear_log();
    sb.push_back('{32'h0, 1'b1, 1'b0});
    run_cmd(1'b1, 32'h0000_0024, 32'h0000_00AA, 32'hFFFF_FFFF, 1'b0, lat);
    check("retry_latency", lat, 4);
    check("retry_nonseq", nonseq_cycles, 1);
    @(negedge hclk);

`ifdef AHB_CFG_MASTER_VERIFY_EN
    // Readback compare, limited to the masked bits.
    aw = 0; dw = 0; err_code = 2'b00; rd_val = 32'h0000_03FF;
    sb.push_back('{32'h0000_03FF, 1'b0, 1'b0});
    run_cmd(1'b1, 32'h0, 32'h0000_01FF, 32'h0000_00FF, 1'b0, lat);
    check("vfy_ok_latency", lat, 5);
    @(negedge hclk);
    rd_val = 32'h0000_00FE;
    sb.push_back('{32'h0000_00FE, 1'b0, 1'b1});
    run_cmd(1'b1, 32'h0, 32'h0000_01FF, 32'h0000_00FF, 1'b0, lat);
    check("vfy_bad_latency", lat, 5);
    @(negedge hclk);
`endif

    // Reset during the data phase abandons the transfer without a response.
    aw = 0; dw = 5; err_code = 2'b00; rd_val = 32'h0BAD_F00D;
    cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h7777_0000; cmd_valid = 1'b1;
    @(negedge hclk);
    cmd_valid = 1'b0;
    @(negedge hclk);
    check("rst_in_data_phase", {31'b0, dut.htrans == 2'b00 && hwdata == 32'h7777_0000}, 32'd1);
    hreset = 1'b1;
    @(negedge hclk);
    check_reset_outputs("midrst");
    hreset = 1'b0;
    dw = 0;
    repeat (6) @(negedge hclk);
    check("midrst_ready", {31'b0, cmd_ready}, 32'd1);
    rd_val = 32'hCAFE_0001;
    clear_log();
    sb.push_back('{32'hCAFE_0001, 1'b0, 1'b0});
    run_cmd(1'b0, 32'h0000_0034, 32'h0, 32'h0, 1'b0, lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_haddr", (log_addr.size() > 0) ? log_addr[0] : 32'hX, 32'h34);
    repeat (3) @(negedge hclk);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
